// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: sequencer that turns an external combinational 4:1 bit mux
// into a 4-bit parallel-to-serial stage.
//
// Flow: a word is taken over the in_valid/in_ready handshake and held on `a`.
// The block then steps `sel` across the four channels and returns each mux
// output bit `y` over the out_valid/out_ready handshake. The final beat of a
// word is flagged with out_last.
//
// Optional feature, enabled with the macro MUX_SCAN_PARITY_EN:
//   After the four data beats, one extra parity beat carrying ^a is sent.
//   out_last is raised only on that beat.
//
// Parameter MSB_FIRST selects the scan direction:
//   0 scans sel 0 -> 3.
//   1 scans sel 3 -> 0.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no word held; in_ready high, waiting for in_valid
// SCAN  | presenting data beats; out_bit follows y for the current sel
// PAR   | (MUX_SCAN_PARITY_EN only) presenting the even-parity beat

module mux_scan_ctrl #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  output logic [3:0] a,
  output logic [1:0] sel,
  input  logic       y,
  output logic       out_valid,
  output logic       out_bit,
  output logic       out_last,
  input  logic       out_ready
);

`ifdef MUX_SCAN_PARITY_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    PAR  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1
  } state_t;
`endif

  localparam logic [1:0] SEL_START = MSB_FIRST ? 2'd3 : 2'd0;
  localparam logic [1:0] SEL_END   = MSB_FIRST ? 2'd0 : 2'd3;

  state_t     state;
  logic       beat_acc;
  logic       load;
  logic [1:0] sel_next;

  // A beat is consumed whenever the presented beat meets downstream ready.
  assign beat_acc = out_valid & out_ready;

  // in_ready is high while idle. It also rises on the accepted last beat, so
  // the next word can load with no bubble. out_last is only set while a beat
  // is presented, so it marks that last beat by itself.
  assign in_ready = (state == IDLE) | (out_last & out_ready);

  // A load happens on any cycle where the input handshake completes.
  // It feeds registers only, so in_valid never reaches out_* combinationally.
  assign load = in_valid & in_ready;

  // Next channel in the scan order.
  assign sel_next = MSB_FIRST ? (sel - 2'd1) : (sel + 2'd1);

  // Serial bit: mux output during data beats, parity during the parity beat,
  // and forced low whenever no beat is presented.
  always_comb begin
    out_bit = 1'b0;
    if (state == SCAN) begin
      out_bit = y;
    end
`ifdef MUX_SCAN_PARITY_EN
    else if (state == PAR) begin
      out_bit = ^a;
    end
`endif
  end

  // Sequencer: held word, select, beat flags and state in one registered FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a         <= 4'd0;
      sel       <= SEL_START;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            a         <= in_data;
            sel       <= SEL_START;
            state     <= SCAN;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
          end
        end

        SCAN: begin
          if (beat_acc) begin
            if (sel != SEL_END) begin
              sel <= sel_next;
`ifdef MUX_SCAN_PARITY_EN
              out_last <= 1'b0;
`else
              // The beat on the end channel is the last beat of the word.
              out_last <= (sel_next == SEL_END);
`endif
            end else begin
`ifdef MUX_SCAN_PARITY_EN
              // Data is done; sel parks on the end channel during parity.
              state    <= PAR;
              out_last <= 1'b1;
`else
              if (load) begin
                a         <= in_data;
                sel       <= SEL_START;
                state     <= SCAN;
                out_valid <= 1'b1;
                out_last  <= 1'b0;
              end else begin
                sel       <= SEL_START;
                state     <= IDLE;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
              end
`endif
            end
          end
        end

`ifdef MUX_SCAN_PARITY_EN
        PAR: begin
          if (beat_acc) begin
            if (load) begin
              a         <= in_data;
              sel       <= SEL_START;
              state     <= SCAN;
              out_valid <= 1'b1;
              out_last  <= 1'b0;
            end else begin
              sel       <= SEL_START;
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end
          end
        end
`endif

        default: begin
          state     <= IDLE;
          sel       <= SEL_START;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Testbench for mux_scan_ctrl.
// Two instances are built, one per scan direction:
//   u_lsb has MSB_FIRST = 0.
//   u_msb has MSB_FIRST = 1.
// Each instance is connected to a behavioural 4:1 mux.

module tb_mux_scan_ctrl;

`ifdef MUX_SCAN_PARITY_EN
  localparam int NBEATS = 5;
`else
  localparam int NBEATS = 4;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid0, in_ready0, out_valid0, out_bit0, out_last0, out_ready0, y0;
  logic [3:0] in_data0, a0;
  logic [1:0] sel0;
  logic       in_valid1, in_ready1, out_valid1, out_bit1, out_last1, out_ready1, y1;
  logic [3:0] in_data1, a1;
  logic [1:0] sel1;

  assign y0 = a0[sel0];
  assign y1 = a1[sel1];

  mux_scan_ctrl #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .a(a0), .sel(sel0), .y(y0), .out_valid(out_valid0), .out_bit(out_bit0),
    .out_last(out_last0), .out_ready(out_ready0));

  mux_scan_ctrl #(.MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .a(a1), .sel(sel1), .y(y1), .out_valid(out_valid1), .out_bit(out_bit1),
    .out_last(out_last1), .out_ready(out_ready1));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic g_ov(input int w);  return (w == 0) ? out_valid0 : out_valid1; endfunction
  function automatic logic g_ob(input int w);  return (w == 0) ? out_bit0   : out_bit1;   endfunction
  function automatic logic g_ol(input int w);  return (w == 0) ? out_last0  : out_last1;  endfunction
  function automatic logic g_ir(input int w);  return (w == 0) ? in_ready0  : in_ready1;  endfunction
  function automatic logic g_iv(input int w);  return (w == 0) ? in_valid0  : in_valid1;  endfunction
  function automatic logic g_or(input int w);  return (w == 0) ? out_ready0 : out_ready1; endfunction
  function automatic logic [3:0] g_id(input int w); return (w == 0) ? in_data0 : in_data1; endfunction
  function automatic logic [1:0] g_sel(input int w); return (w == 0) ? sel0 : sel1; endfunction

  task automatic drv(input int w, input logic iv, input logic [3:0] d, input logic r);
    if (w == 0) begin
      in_valid0 = iv; in_data0 = d; out_ready0 = r;
    end else begin
      in_valid1 = iv; in_data1 = d; out_ready1 = r;
    end
  endtask

  // Reference beat k of word wd, packed as {last, bit, sel[1:0]}.
  // It is derived from the scan order, not from the FSM.
  function automatic logic [3:0] exp_beat(input logic [3:0] wd, input bit msb, input int k);
    int s;
    logic b;
    logic l;
    if (k < 4) begin
      s = msb ? 3 - k : k;
      b = wd[s];
    end else begin
      s = msb ? 0 : 3;
      b = ^wd;
    end
    l = (k == NBEATS - 1);
    return {l, b, 2'(s)};
  endfunction

  typedef struct {
    int         which;
    logic [3:0] word;
    logic [3:0] bits;   // expected data bit of beat k at bits[k]
    logic [7:0] sels;   // expected sel of beat k at sels[2k+:2]
  } vec_t;

  vec_t vecs[$];

  // Load one word with out_ready=1 and check every beat against the table.
  task automatic run_vec(input vec_t v);
    logic [1:0] es;
    logic       eb;
    logic [7:0] sv;
    logic [3:0] bv;
    sv = v.sels;
    bv = v.bits;
    @(posedge clk); #1;
    drv(v.which, 1'b1, v.word, 1'b1);
    @(negedge clk);
    chk("vec_idle_in_ready", 4'(g_ir(v.which)), 4'd1);
    chk("vec_idle_out_valid", 4'(g_ov(v.which)), 4'd0);
    @(posedge clk); #1;
    drv(v.which, 1'b0, 4'd0, 1'b1);
    for (int k = 0; k < NBEATS; k++) begin
      @(negedge clk);
      if (k < 4) begin
        es = sv[2*k +: 2];
        eb = bv[k];
      end else begin
        es = sv[7:6];
        eb = ^v.word;
      end
      chk("vec_out_valid", 4'(g_ov(v.which)), 4'd1);
      chk("vec_sel", 4'(g_sel(v.which)), 4'(es));
      chk("vec_out_bit", 4'(g_ob(v.which)), 4'(eb));
      chk("vec_out_last", 4'(g_ol(v.which)), 4'(k == NBEATS - 1));
      chk("vec_in_ready", 4'(g_ir(v.which)), 4'(k == NBEATS - 1));
      @(posedge clk);
    end
    @(negedge clk);
    chk("vec_after_out_valid", 4'(g_ov(v.which)), 4'd0);
    chk("vec_after_in_ready", 4'(g_ir(v.which)), 4'd1);
  endtask

  // Scoreboard state for the randomized phase: a small ring of pending beats.
  logic [3:0] sb [2][16];
  int         sb_rd [2];
  int         sb_cnt [2];

  task automatic model_step(input int w);
    logic [3:0] hd;
    logic       exp_ir;
    logic [3:0] d;
    exp_ir = (sb_cnt[w] == 0) || (sb_cnt[w] == 1 && g_or(w));
    chk("rnd_out_valid", 4'(g_ov(w)), 4'(sb_cnt[w] > 0));
    chk("rnd_in_ready", 4'(g_ir(w)), 4'(exp_ir));
    if (sb_cnt[w] > 0) begin
      hd = sb[w][sb_rd[w]];
      chk("rnd_sel", 4'(g_sel(w)), 4'(hd[1:0]));
      chk("rnd_out_bit", 4'(g_ob(w)), 4'(hd[2]));
      chk("rnd_out_last", 4'(g_ol(w)), 4'(hd[3]));
      if (g_or(w)) begin
        sb_rd[w] = (sb_rd[w] + 1) % 16;
        sb_cnt[w]--;
      end
    end else begin
      chk("rnd_idle_bit", 4'(g_ob(w)), 4'd0);
    end
    if (g_iv(w) && exp_ir) begin
      d = g_id(w);
      for (int k = 0; k < NBEATS; k++) begin
        sb[w][(sb_rd[w] + sb_cnt[w]) % 16] = exp_beat(d, w == 1, k);
        sb_cnt[w]++;
      end
    end
  endtask

  initial begin
    logic [3:0] eb4;
    logic [3:0] w2;

    rst = 1'b1;
    drv(0, 1'b0, 4'd0, 1'b1);
    drv(1, 1'b0, 4'd0, 1'b1);

    // Reset values for both directions.
    #2;
    chk("rst_a", a0, 4'd0);
    chk("rst_sel_lsb", 4'(sel0), 4'd0);
    chk("rst_sel_msb", 4'(sel1), 4'd3);
    chk("rst_in_ready", 4'(in_ready0), 4'd1);
    chk("rst_out_valid", 4'(out_valid0), 4'd0);
    chk("rst_out_last", 4'(out_last1), 4'd0);
    chk("rst_out_bit", 4'(out_bit0), 4'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed table.
    vecs.push_back('{0, 4'b1010, 4'b1010, 8'b11_10_01_00});
    vecs.push_back('{1, 4'b1100, 4'b0011, 8'b00_01_10_11});
    vecs.push_back('{0, 4'b0110, 4'b0110, 8'b11_10_01_00});
    vecs.push_back('{1, 4'b0101, 4'b1010, 8'b00_01_10_11});
    vecs.push_back('{0, 4'b1011, 4'b1011, 8'b11_10_01_00});
    foreach (vecs[i]) run_vec(vecs[i]);

`ifdef MUX_SCAN_PARITY_EN
    // Spot check: the parity beat of 1011 is 1.
    chk("parity_1011", 4'(^vecs[4].word), 4'd1);
`endif

    // Back-pressure on 1111: stall at beat 2 for three cycles.
    @(posedge clk); #1;
    drv(0, 1'b1, 4'b1111, 1'b1);
    @(posedge clk); #1;
    drv(0, 1'b0, 4'd0, 1'b1);
    @(negedge clk);
    chk("bp_beat1_sel", 4'(sel0), 4'd0);
    @(posedge clk); #1;
    drv(0, 1'b0, 4'd0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_hold_valid", 4'(out_valid0), 4'd1);
      chk("bp_hold_sel", 4'(sel0), 4'd1);
      chk("bp_hold_bit", 4'(out_bit0), 4'd1);
      chk("bp_hold_last", 4'(out_last0), 4'd0);
      chk("bp_hold_in_ready", 4'(in_ready0), 4'd0);
      @(posedge clk); #1;
    end
    drv(0, 1'b0, 4'd0, 1'b1);
    for (int k = 1; k < NBEATS; k++) begin
      eb4 = exp_beat(4'b1111, 1'b0, k);
      @(negedge clk);
      chk("bp_resume_valid", 4'(out_valid0), 4'd1);
      chk("bp_resume_sel", 4'(sel0), 4'(eb4[1:0]));
      chk("bp_resume_bit", 4'(out_bit0), 4'(eb4[2]));
      chk("bp_resume_last", 4'(out_last0), 4'(eb4[3]));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("bp_done_valid", 4'(out_valid0), 4'd0);

    // Back-to-back: 0001 then 1000, with the second load on the last beat.
    @(posedge clk); #1;
    drv(0, 1'b1, 4'b0001, 1'b1);
    @(posedge clk); #1;
    drv(0, 1'b0, 4'd0, 1'b1);
    for (int k = 0; k < 2 * NBEATS; k++) begin
      w2 = (k < NBEATS) ? 4'b0001 : 4'b1000;
      eb4 = exp_beat(w2, 1'b0, k % NBEATS);
      if (k == NBEATS - 1) drv(0, 1'b1, 4'b1000, 1'b1);
      @(negedge clk);
      chk("b2b_valid", 4'(out_valid0), 4'd1);
      chk("b2b_bit", 4'(out_bit0), 4'(eb4[2]));
      chk("b2b_last", 4'(out_last0), 4'(eb4[3]));
      if (k == NBEATS - 1) chk("b2b_in_ready", 4'(in_ready0), 4'd1);
      @(posedge clk); #1;
      if (k == NBEATS - 1) drv(0, 1'b0, 4'd0, 1'b1);
    end
    @(negedge clk);
    chk("b2b_done_valid", 4'(out_valid0), 4'd0);

    // Asynchronous reset during beat 2 of 0110.
    @(posedge clk); #1;
    drv(0, 1'b1, 4'b0110, 1'b1);
    @(posedge clk); #1;
    drv(0, 1'b0, 4'd0, 1'b1);
    @(posedge clk); #1;
    chk("pre_rst_sel", 4'(sel0), 4'd1);
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 4'(out_valid0), 4'd0);
    chk("arst_a", a0, 4'd0);
    chk("arst_sel", 4'(sel0), 4'd0);
    chk("arst_in_ready", 4'(in_ready0), 4'd1);
    chk("arst_out_bit", 4'(out_bit0), 4'd0);
    chk("arst_out_last", 4'(out_last0), 4'd0);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("arst_no_replay", 4'(out_valid0), 4'd0);

    // Randomized phase on both instances against the scoreboard.
    for (int w = 0; w < 2; w++) begin
      sb_rd[w] = 0;
      sb_cnt[w] = 0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk); #1;
      for (int w = 0; w < 2; w++) begin
        if (cyc < 580)
          drv(w, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              ($urandom_range(0, 3) != 0));
        else
          drv(w, 1'b0, 4'($urandom_range(0, 15)), 1'b1);
      end
      @(negedge clk);
      for (int w = 0; w < 2; w++) model_step(w);
    end
    for (int w = 0; w < 2; w++) chk("rnd_drained", 4'(sb_cnt[w]), 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Upstream sequencer for the 4:1 bit multiplexer. It accepts a 4-bit word over a valid/ready handshake, holds it on the mux data inputs, and steps the mux select through all four channels. It returns each selected bit `y` as a serial stream over a second valid/ready handshake with a last-beat flag. It turns the combinational mux into a 4-bit parallel-to-serial stage.

## Interface
Parameters:
- `MSB_FIRST`, default 0: 0 scans sel 0→3; 1 scans sel 3→0.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a word.
- `in_data`  in  4  word to serialize.
- `a`  out  4  held word, drives mux `a`.
- `sel`  out  2  drives mux `sel`.
- `y`  in  1  mux output, equal to `a[sel]` combinationally.
- `out_valid`  out  1  `out_bit` is valid.
- `out_bit`  out  1  current serial bit.
- `out_last`  out  1  final beat of the word.
- `out_ready`  in  1  downstream accepts the beat.

## Operation
- FSM states: IDLE, SCAN, and PAR (PAR exists only with the macro).
- Reset values:
  - state = IDLE.
  - `a` = 0.
  - `sel` = start index: 0, or 3 when `MSB_FIRST`.
  - `in_ready` = 1.
  - `out_valid` = 0, `out_last` = 0, `out_bit` = 0.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid & in_ready`: `a` ← `in_data`, `sel` ← start index, go to SCAN.
- SCAN:
  - `out_valid` = 1 and `out_bit` = `y`.
  - On `out_valid & out_ready`, if `sel` ≠ end index (3, or 0 when `MSB_FIRST`): `sel` steps ±1.
  - If `sel` = end index:
    - Without the macro: `out_last` = 1, and the beat ends the word.
    - With the macro: the beat goes to PAR.
- Word completion, on the accepted last beat:
  - `in_ready` = 1 combinationally during that beat, allowing a back-to-back load.
  - If `in_valid` is also high: load the new word, `sel` ← start index, stay in SCAN.
  - Otherwise: go to IDLE.
- Outside valid beats, `out_bit` is forced to 0 (it is not `y`).
- When `out_ready` = 0: `sel`, `a`, `out_bit` and `out_last` stay stable. The beat is held and never dropped.
- `in_ready` = 0 in SCAN except on the accepted last beat; `in_data` is ignored.
- Asynchronous reset mid-word: the word is abandoned immediately and all outputs take their reset values. No partial beats are replayed.

## Timing
- Load-to-first-beat latency: 1 cycle. `out_valid` rises on the edge that accepts `in_data`.
- Throughput with `out_ready` held at 1:
  - Without the macro: 4 beats per word, no bubble between words when back-to-back.
  - With the macro: 5 beats per word.
- `sel` changes only on a clock edge where the beat is accepted. The mux is combinational, so `y` is valid in the same cycle.
- Sole combinational paths:
  - `out_bit` from `y`.
  - `in_ready` from `out_ready` (last beat only).
  - No path from `in_valid` to `out_*`.

## Configuration
- Macro `MUX_SCAN_PARITY_EN`.
- Defined:
  - After the 4 data beats, PAR emits one extra beat with `out_bit` = `^a` (even parity over the held word).
  - `out_last` = 1 only on the parity beat.
  - `sel` holds at the end index during PAR.
  - The back-to-back load applies on the parity beat.
- Undefined:
  - The PAR state and parity logic are absent.
  - `out_last` is asserted on the 4th data beat.

## Test plan
- Reset, then load 4'b1010 with `MSB_FIRST`=0 and `out_ready`=1:
  - `sel` = 0,1,2,3 and `out_bit` = 0,1,0,1.
  - `out_last` only on beat 4.
  - IDLE with `in_ready`=1 the next cycle.
- Load 4'b1100 with `MSB_FIRST`=1: `sel` = 3,2,1,0 and `out_bit` = 1,1,0,0.
- Back-pressure on word 4'b1111: drop `out_ready` for 3 cycles at beat 2. `sel` holds at 1 and `out_bit`=1 throughout; resume with no lost or duplicated beat.
- Back-to-back loads 4'b0001 then 4'b1000 with `in_valid` high on the last beat of the first word: 8 consecutive valid beats, 1,0,0,0,0,0,0,1, with no IDLE cycle.
- Assert `rst` during beat 2 of 4'b0110: the same cycle shows `out_valid`=0, `a`=0, `sel`=0, `in_ready`=1.
- With `MUX_SCAN_PARITY_EN`, load 4'b1011: 5 beats 1,1,0,1,1, where the 5th beat is parity = 1 and is the only beat with `out_last`=1.
